// File: rtl/crc7_rx_check.sv
// crc7_rx_check: serial command-frame receiver with CRC7 and end-bit checking.
// Ports:
//    clk        sole clock, rising edge
//    rst        asynchronous active-low reset
//    start      one-cycle pulse arming reception of one frame (re-arms if busy)
//    bit_in     serial data, frame MSB first; qualified by bit_valid
//    busy       high from accepted start until done
//    done       one-cycle pulse on frame completion or hunt timeout
//    crc_ok     received CRC7 matched the locally computed CRC7
//    end_ok     received end bit was 1
//    timeout    no start bit seen within HUNT_MAX valid bits
//    frame_out  frame bits 47..8 (start, dir, index, arg)
//    crc_rx     received CRC field
//    crc_calc   locally computed CRC7
module crc7_rx_check #(
   parameter int HUNT_MAX = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        bit_in,
   input  logic        bit_valid,
   output logic        busy,
   output logic        done,
   output logic        crc_ok,
   output logic        end_ok,
   output logic        timeout,
   output logic [39:0] frame_out,
   output logic [6:0]  crc_rx,
   output logic [6:0]  crc_calc
);
   typedef enum logic [2:0] {IDLE, HUNT, BODY, CRC, STOP} state_t;
   localparam logic [7:0] HUNT_LAST = 8'(HUNT_MAX - 1);
   state_t      r_state, w_state_nxt;
   logic [5:0]  r_bit_cnt;
   logic [7:0]  r_hunt_cnt;
   logic [6:0]  r_crc, w_crc_nxt;
   logic [39:0] r_frame;
   logic [6:0]  r_crc_rx, r_crc_calc;
   logic        r_busy, r_done, r_crc_ok, r_end_ok, r_timeout;
   logic        w_take, w_tmo, w_fin;
   always_comb begin
      // start takes priority over any bit; bits are never consumed in IDLE
      w_take    = bit_valid && !start && r_state != IDLE;
      w_tmo     = w_take && r_state == HUNT && bit_in && r_hunt_cnt == HUNT_LAST;
      w_fin     = w_take && r_state == STOP;
      w_crc_nxt = {r_crc[5:0], 1'b0} ^ ((r_crc[6] ^ bit_in) ? 7'h09 : 7'h00);
      w_state_nxt = r_state;
      if (start)
         w_state_nxt = HUNT;
      else if (w_take)
         case (r_state)
            HUNT:    w_state_nxt = bit_in ? (w_tmo ? IDLE : HUNT) : BODY;
            BODY:    w_state_nxt = (r_bit_cnt == 6'd39) ? CRC : BODY;
            CRC:     w_state_nxt = (r_bit_cnt == 6'd6) ? STOP : CRC;
            STOP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
         endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_bit_cnt  <= '0;
         r_hunt_cnt <= '0;
         r_crc      <= '0;
         r_frame    <= '0;
         r_crc_rx   <= '0;
         r_crc_calc <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_crc_ok   <= 1'b0;
         r_end_ok   <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= w_state_nxt != IDLE;
         r_done  <= w_tmo || w_fin;
         if (start) begin
            r_bit_cnt  <= '0;
            r_hunt_cnt <= '0;
            r_crc      <= '0;
            r_frame    <= '0;
            r_crc_rx   <= '0;
            r_crc_ok   <= 1'b0;
            r_end_ok   <= 1'b0;
            r_timeout  <= 1'b0;
         end else if (w_take)
            case (r_state)
               HUNT:
                  if (bit_in) begin
                     r_hunt_cnt <= r_hunt_cnt + 8'd1;
                     if (w_tmo) begin
                        r_timeout <= 1'b1;
                        r_crc_ok  <= 1'b0;
                        r_end_ok  <= 1'b0;
                     end
                  end else begin
                     r_frame   <= {r_frame[38:0], 1'b0};
                     r_crc     <= w_crc_nxt;
                     r_bit_cnt <= 6'd1;
                  end
               BODY: begin
                  r_frame   <= {r_frame[38:0], bit_in};
                  r_crc     <= w_crc_nxt;
                  r_bit_cnt <= (r_bit_cnt == 6'd39) ? 6'd0 : r_bit_cnt + 6'd1;
               end
               CRC: begin
                  r_crc_rx  <= {r_crc_rx[5:0], bit_in};
                  r_bit_cnt <= r_bit_cnt + 6'd1;
               end
               STOP: begin
                  r_end_ok   <= bit_in;
                  r_crc_ok   <= r_crc_rx == r_crc;
                  r_crc_calc <= r_crc;
               end
               default: ;
            endcase
      end
   end
   assign busy      = r_busy;
   assign done      = r_done;
   assign crc_ok    = r_crc_ok;
   assign end_ok    = r_end_ok;
   assign timeout   = r_timeout;
   assign frame_out = r_frame;
   assign crc_rx    = r_crc_rx;
   assign crc_calc  = r_crc_calc;
endmodule

// File: tb/tb_crc7_rx_check.sv
// tb_crc7_rx_check: scoreboard bench for crc7_rx_check with directed frames.
module tb_crc7_rx_check;
   logic        clk = 1'b0, rst = 1'b0, start = 1'b0, bit_in = 1'b0, bit_valid = 1'b0;
   logic        busy, done, crc_ok, end_ok, timeout;
   logic [39:0] frame_out;
   logic [6:0]  crc_rx, crc_calc;
   int total = 0, bad = 0;
   typedef struct {
      logic        ok, eok, tmo;
      logic [39:0] fr;
      logic [6:0]  rx, calc;
      bit          chk_calc;
   } exp_t;
   exp_t q[$];
   crc7_rx_check #(.HUNT_MAX(16)) dut (
      .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
      .busy(busy), .done(done), .crc_ok(crc_ok), .end_ok(end_ok), .timeout(timeout),
      .frame_out(frame_out), .crc_rx(crc_rx), .crc_calc(crc_calc)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   // monitor: every done pulse must match the oldest pending expectation
   always @(negedge clk) begin
      if (rst && done) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got done=1 expected none at %0t", $time);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("busy_at_done", 48'(busy), 48'(0));
            chk("crc_ok", 48'(crc_ok), 48'(e.ok));
            chk("end_ok", 48'(end_ok), 48'(e.eok));
            chk("timeout", 48'(timeout), 48'(e.tmo));
            chk("frame_out", 48'(frame_out), 48'(e.fr));
            chk("crc_rx", 48'(crc_rx), 48'(e.rx));
            if (e.chk_calc) chk("crc_calc", 48'(crc_calc), 48'(e.calc));
         end
      end
   end
   task automatic push(input logic ok, input logic eok, input logic tmo, input logic [39:0] fr,
                       input logic [6:0] rx, input logic [6:0] calc, input bit cc);
      exp_t e;
      e.ok = ok; e.eok = eok; e.tmo = tmo; e.fr = fr; e.rx = rx; e.calc = calc; e.chk_calc = cc;
      q.push_back(e);
   endtask
   task automatic pulse_start(input logic with_bit);
      @(negedge clk);
      start = 1'b1;
      bit_valid = with_bit;
      bit_in = 1'b0;
      @(negedge clk);
      start = 1'b0;
      bit_valid = 1'b0;
   endtask
   task automatic send_bit(input logic b, input bit gaps);
      if (gaps)
         repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            bit_valid = 1'b0;
            bit_in = 1'($urandom);
         end
      @(negedge clk);
      bit_valid = 1'b1;
      bit_in = b;
   endtask
   task automatic send_bits(input logic [47:0] f, input int n, input bit gaps);
      for (int i = 47; i > 47 - n; i--) send_bit(f[i], gaps);
   endtask
   // done must appear exactly one cycle after the edge that sampled the last bit
   task automatic finish(input string name);
      @(negedge clk);
      bit_valid = 1'b0;
      chk({name, "_done_lat"}, 48'(done), 48'(1));
      @(negedge clk);
      chk({name, "_done_once"}, 48'(done), 48'(0));
   endtask
   localparam logic [47:0] CMD0     = {40'h4000000000, 7'h4A, 1'b1};
   localparam logic [47:0] CMD8_BAD = {40'h48000001AA, 7'h42, 1'b1};
   localparam logic [47:0] CMD17    = {40'h5100000000, 7'h2A, 1'b0};
   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish by 200000");
      $fatal(1);
   end
   initial begin
      #12;
      chk("rst_busy", 48'(busy), 48'(0));
      chk("rst_done", 48'(done), 48'(0));
      chk("rst_frame", 48'(frame_out), 48'(0));
      chk("rst_calc", 48'(crc_calc), 48'(0));
      @(negedge clk);
      rst = 1'b1;
      // CMD0, with a bit presented alongside start that must be ignored
      pulse_start(1'b1);
      chk("busy_armed", 48'(busy), 48'(1));
      push(1, 1, 0, 40'h4000000000, 7'h4A, 7'h4A, 1);
      send_bits(CMD0, 48, 0);
      finish("cmd0");
      chk("hold_frame", 48'(frame_out), 48'h4000000000);
      // CMD8 with corrupted CRC
      pulse_start(1'b0);
      push(0, 1, 0, 40'h48000001AA, 7'h42, 7'h43, 1);
      send_bits(CMD8_BAD, 48, 0);
      finish("cmd8");
      // CMD17 after idle ones with random valid gaps, end bit 0
      pulse_start(1'b0);
      push(1, 0, 0, 40'h5100000000, 7'h2A, 7'h2A, 1);
      repeat (5) send_bit(1'b1, 1);
      send_bits(CMD17, 48, 1);
      finish("cmd17");
      // hunt timeout: 15 ones must not finish, 16th must
      pulse_start(1'b0);
      repeat (15) send_bit(1'b1, 0);
      @(negedge clk);
      bit_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("hunt_still_busy", 48'(busy), 48'(1));
      push(0, 0, 1, 40'h0, 7'h0, 7'h0, 0);
      send_bit(1'b1, 0);
      finish("tmo");
      // async reset mid-frame
      pulse_start(1'b0);
      send_bits(CMD0, 20, 0);
      @(negedge clk);
      bit_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("arst_busy", 48'(busy), 48'(0));
      chk("arst_frame", 48'(frame_out), 48'(0));
      chk("arst_timeout", 48'(timeout), 48'(0));
      @(negedge clk);
      rst = 1'b1;
      pulse_start(1'b0);
      push(1, 1, 0, 40'h4000000000, 7'h4A, 7'h4A, 1);
      send_bits(CMD0, 48, 0);
      finish("post_rst");
      // start re-pulsed mid-frame aborts without done
      pulse_start(1'b0);
      send_bits(CMD0, 10, 0);
      pulse_start(1'b0);
      chk("rearm_busy", 48'(busy), 48'(1));
      push(1, 1, 0, 40'h4000000000, 7'h4A, 7'h4A, 1);
      send_bits(CMD0, 48, 0);
      finish("rearm");
      repeat (5) @(negedge clk);
      chk("queue_empty", 48'(q.size()), 48'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/crc7_rx_check.md
CRC7_RX_CHECK -- requirements
Module: crc7_rx_check

Interface
REQ-001 SHALL have parameter HUNT_MAX, default 16, giving the max valid bits searched for a start bit before timeout (range 1..255).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  one-cycle pulse arming reception of one frame.
REQ-005 SHALL have port bit_in  input  1  serial data bit, MSB of frame first (SPI MISO / CMD line sample).
REQ-006 SHALL have port bit_valid  input  1  qualifies bit_in; bits consumed only when high.
REQ-007 SHALL have port busy  output  1  high from accepted start until done.
REQ-008 SHALL have port done  output  1  one-cycle pulse when frame completes or times out.
REQ-009 SHALL have port crc_ok  output  1  received CRC7 equals computed CRC7.
REQ-010 SHALL have port end_ok  output  1  received end bit was 1.
REQ-011 SHALL have port timeout  output  1  no start bit within HUNT_MAX valid bits.
REQ-012 SHALL have port frame_out  output  40  received frame bits 47..8 (start, dir, index, arg).
REQ-013 SHALL have port crc_rx  output  7  received CRC field.
REQ-014 SHALL have port crc_calc  output  7  locally computed CRC7.

Function
REQ-015 SHALL implement states IDLE, HUNT, BODY, CRC, STOP; all outputs registered.
REQ-016 SHALL, in IDLE on start=1, clear crc accumulator, frame/crc_rx shift registers, bit and hunt counters, clear crc_ok/end_ok/timeout, go to HUNT, busy=1 next cycle.
REQ-017 SHALL, in HUNT, on each valid bit_in=1 increment hunt counter; on valid bit_in=0 treat it as start bit: shift into frame, feed into CRC, bit counter=1, go to BODY.
REQ-018 SHALL, in HUNT, when the HUNT_MAX-th valid bit is 1, set timeout=1, crc_ok=0, end_ok=0, pulse done, return to IDLE.
REQ-019 SHALL, in BODY, shift each valid bit into frame_out LSB-side and update CRC; after bit 40 go to CRC.
REQ-020 SHALL update CRC7 (poly x^7+x^3+1, init 7'h00) per bit: fb = crc[6]^bit; crc = {crc[5:0],1'b0} ^ (fb ? 7'h09 : 7'h00).
REQ-021 SHALL, in CRC, shift 7 valid bits into crc_rx without updating the accumulator, then go to STOP.
REQ-022 SHALL, in STOP, on the valid end bit: end_ok=bit_in, crc_ok=(crc_rx==crc accumulator), crc_calc=accumulator; go to IDLE.
REQ-023 SHALL pulse done for exactly one cycle, in the cycle after the edge sampling the end bit (or the timeout bit); busy deasserts in that same cycle.
REQ-024 SHALL hold frame_out, crc_rx, crc_calc, crc_ok, end_ok, timeout stable after done until next accepted start.
REQ-025 SHALL ignore bit_in while bit_valid=0 in any state; gaps of any length allowed.
REQ-026 SHALL, on start=1 while busy, abort the current frame and re-arm as in REQ-016 without pulsing done.
REQ-027 SHALL, when start and bit_valid are high in the same IDLE cycle, ignore that bit.
REQ-028 SHALL ignore bit_valid in IDLE.

Reset
REQ-029 SHALL, on rst=0, immediately force IDLE, busy=0, done=0, crc_ok=0, end_ok=0, timeout=0, frame_out=0, crc_rx=0, crc_calc=0, counters=0, regardless of clk.
REQ-030 SHALL, on reset mid-frame, discard the partial frame and emit no done.

Verification
REQ-031 SHALL test CMD0 frame 0x40_00000000, crc 0x4A, end 1 -> done once, crc_ok=1, end_ok=1, crc_calc=0x4A, frame_out=0x4000000000.
REQ-032 SHALL test CMD8 frame 0x48_000001AA with crc 0x42 (corrupted, correct 0x43) -> crc_ok=0, crc_calc=0x43, crc_rx=0x42.
REQ-033 SHALL test CMD17 frame 0x51_00000000, crc 0x2A, end bit 0, preceded by 5 idle 1-bits and random bit_valid gaps -> crc_ok=1, end_ok=0, timeout=0.
REQ-034 SHALL test HUNT_MAX=16 with 16 valid 1-bits -> done after 16th bit, timeout=1, crc_ok=0.
REQ-035 SHALL test rst=0 asserted after 20 bits of a frame, then a CMD0 frame -> no done from aborted frame, second frame crc_ok=1.
REQ-036 SHALL test start re-pulsed after 10 bits, then CMD0 frame -> exactly one done, crc_ok=1.
